uart_receive: RTL and testbench

- Serial-to-parallel UART receiver that consumes the line driven by the team's `transmit` stage.
- Frame format: 1 start bit (0), `bits` data bits LSB first, optional parity bit, 1 stop bit (1); idle line is 1.
- Oversamples `rx` on a sample-tick enable, recovers each bit at mid-bit, and presents the received word on a valid/ready interface to downstream logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync2.sv | 31 +++
 rtl/uart_receive.sv | 211 +++++++++++++++++++++
 tb/tb_uart_receive.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive/transmit types, framing constants and parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   MAX_BITS  = 16;

  // Even parity holds when data bits plus parity bit XOR to zero; unused upper bits are zero.
  function automatic logic even_parity_ok(input logic [MAX_BITS-1:0] data, input logic par);
    return ~((^data) ^ par);
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with configurable reset value
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - oversampling UART receiver with valid/ready output
// Optional even-parity checking and parity_err output enabled by UART_RX_PARITY_EN.
module uart_receive
  import uart_pkg::*;
#(
  parameter int bits = 8,
  parameter int OVS  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            rx,
  output logic [bits-1:0] out,
  output logic            valid,
  input  logic            ready,
  output logic            busy,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            overrun
);

  localparam int CW   = $clog2(OVS);
  localparam int IDXW = $clog2(bits) + 1;

  localparam logic [CW-1:0]   HALF_CNT = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(OVS - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(bits - 1);

  logic rx_s;

  state_t          state_d, state_q;
  logic [CW-1:0]   cnt_d, cnt_q;
  logic [IDXW-1:0] idx_d, idx_q;
  logic [bits-1:0] shreg_d, shreg_q;
  logic [bits-1:0] out_d, out_q;
  logic            valid_d, valid_q;
  logic            busy_d, busy_q;
  logic            frame_err_d, frame_err_q;
  logic            overrun_d, overrun_q;
  logic            load;
`ifdef UART_RX_PARITY_EN
  logic            par_d, par_q;
  logic            parity_err_d, parity_err_q;
`endif

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (en && rx_s == START_BIT) begin
          cnt_d   = '0;
          state_d = START;
        end
      end

      START: begin
        if (en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HALF_CNT) begin
            if (rx_s == START_BIT) begin
              cnt_d   = '0;
              idx_d   = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      DATA: begin
        if (en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == FULL_CNT) begin
            cnt_d = '0;
            for (int i = 0; i < bits; i++) begin
              if (idx_q == IDXW'(i)) shreg_d[i] = rx_s;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == FULL_CNT) begin
            cnt_d   = '0;
            par_d   = rx_s;
            state_d = STOP;
          end
        end
      end
`endif

      STOP: begin
        if (en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == FULL_CNT) begin
            cnt_d = '0;
            if (rx_s == STOP_BIT) begin
`ifdef UART_RX_PARITY_EN
              if (even_parity_ok(MAX_BITS'(shreg_q), par_q)) load = 1'b1;
              else parity_err_d = 1'b1;
`else
              load = 1'b1;
`endif
              state_d = IDLE;
            end else begin
              // Line held low through the stop bit: wait for it to rise so a break is not a start.
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end
        end
      end

      WAIT_HIGH: begin
        if (rx_s == STOP_BIT) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d     = out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      out_d   = shreg_q;
      valid_d = 1'b1;
      if (valid_q && !ready) overrun_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign out       = out_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receive.sv
// tb/tb_uart_receive.sv - directed self-checking bench for uart_receive
// Parity steps run only when UART_RX_PARITY_EN is defined.
module tb_uart_receive;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam logic USE_PAR = 1'b1;
`else
  localparam logic USE_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] out;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       en;
  logic [1:0] div_q = 2'd0;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int busy_rises = 0;
  int align_cnt = 0;
  logic busy_prev = 1'b0;
  logic valid_prev = 1'b0;
  int fe_base, pe_base, br_base, al_base;

  always #5 clk = ~clk;

  always @(posedge clk) div_q <= div_q + 2'd1;
  assign en = (div_q == 2'd3);

  uart_receive #(.bits(8), .OVS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rx        (rx),
    .out       (out),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always @(posedge clk) begin
    busy_prev  <= busy;
    valid_prev <= valid;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (busy && !busy_prev) busy_rises <= busy_rises + 1;
    if (valid && !valid_prev && !busy && busy_prev) align_cnt <= align_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par_bit,
                            input logic stop_bit, input int stop_clks);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (use_par) send_bit(par_bit);
    rx = stop_bit;
    wait_clks(stop_clks);
  endtask

  task automatic consume();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    rx    = 1'b1;
    ready = 1'b0;
    rst_n = 1'b0;
    wait_clks(5);
    check("reset_out", 32'(out), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    wait_clks(40);

    // Clean 0xA5 frame
    fe_base = fe_cnt;
    al_base = align_cnt;
    send_frame(8'hA5, USE_PAR, ^8'hA5, 1'b1, 8);
    check("a5_valid_before_stop_mid", 32'(valid), 32'h0);
    wait_clks(BIT_CLKS - 8);
    check("a5_out", 32'(out), 32'hA5);
    check("a5_valid", 32'(valid), 32'h1);
    check("a5_busy_idle", 32'(busy), 32'h0);
    check("a5_no_frame_err", 32'(fe_cnt - fe_base), 32'h0);
    check("a5_no_overrun", 32'(overrun), 32'h0);
    check("a5_valid_with_idle", 32'(align_cnt - al_base), 32'h1);
    consume();
    check("a5_valid_cleared", 32'(valid), 32'h0);
    check("a5_out_held", 32'(out), 32'hA5);
    wait_clks(40);

    // Start-bit glitch
    br_base = busy_rises;
    rx = 1'b0;
    wait_clks(12);
    rx = 1'b1;
    wait_clks(80);
    check("glitch_busy_pulsed", 32'(busy_rises - br_base), 32'h1);
    check("glitch_busy_idle", 32'(busy), 32'h0);
    check("glitch_valid", 32'(valid), 32'h0);
    check("glitch_no_frame_err", 32'(fe_cnt - fe_base), 32'h0);

    // Framing error with long break, then recovery
    send_frame(8'h3C, USE_PAR, ^8'h3C, 1'b0, 160);
    check("break_frame_err_one_cycle", 32'(fe_cnt - fe_base), 32'h1);
    check("break_valid", 32'(valid), 32'h0);
    check("break_wait_high_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_clks(16);
    check("break_released_idle", 32'(busy), 32'h0);
    wait_clks(40);
    send_frame(8'h11, USE_PAR, ^8'h11, 1'b1, BIT_CLKS);
    check("after_break_out", 32'(out), 32'h11);
    check("after_break_valid", 32'(valid), 32'h1);
    check("after_break_fe_count", 32'(fe_cnt - fe_base), 32'h1);
    consume();
    wait_clks(20);

    // Back-to-back frames without consumption
    send_frame(8'h01, USE_PAR, ^8'h01, 1'b1, BIT_CLKS);
    check("ovr_first_out", 32'(out), 32'h01);
    check("ovr_first_no_overrun", 32'(overrun), 32'h0);
    send_frame(8'h02, USE_PAR, ^8'h02, 1'b1, BIT_CLKS);
    check("ovr_second_out", 32'(out), 32'h02);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_valid", 32'(valid), 32'h1);
    consume();
    check("ovr_valid_cleared", 32'(valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    wait_clks(20);

    // Reset in the middle of data bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    wait_clks(32);
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    wait_clks(10);
    rst_n = 1'b1;
    wait_clks(4 * BIT_CLKS);
    check("midrst_stays_idle", 32'(busy), 32'h0);
    send_frame(8'h5A, USE_PAR, ^8'h5A, 1'b1, BIT_CLKS);
    check("after_rst_out", 32'(out), 32'h5A);
    check("after_rst_valid", 32'(valid), 32'h1);
    check("after_rst_overrun", 32'(overrun), 32'h0);
    consume();
    wait_clks(20);

`ifdef UART_RX_PARITY_EN
    pe_base = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, BIT_CLKS);
    check("par_bad_pulse", 32'(pe_cnt - pe_base), 32'h1);
    check("par_bad_valid", 32'(valid), 32'h0);
    check("par_bad_out_kept", 32'(out), 32'h5A);
    wait_clks(20);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, BIT_CLKS);
    check("par_good_out", 32'(out), 32'h07);
    check("par_good_valid", 32'(valid), 32'h1);
    check("par_good_no_pulse", 32'(pe_cnt - pe_base), 32'h1);
`else
    pe_base = pe_cnt;
    check("no_parity_pulses", 32'(pe_cnt - pe_base), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
